as_hazard_scoreboard: RTL and testbench
=======================================

# as_hazard_scoreboard

Parametrised hazard unit for the 5-stage RV64I pipeline. It generates EX-stage forwarding selects for `NUM_RS` read ports and stalls ID on load-use, RAW and WAW hazards. A per-register busy scoreboard tracks long-latency operations (divider, slow memory) that complete out of band. It sits beside the ID/EX pipeline registers: it drives the EX operand muxes and the PC/IF-ID/ID-EX stall and bubble controls, and it keeps a saturating stall-cycle counter for performance analysis.

## Interface
- `NUM_RS`, 2: number of source-register read ports per instruction.
- `MAX_PEND`, 4: maximum outstanding long-latency operations, ≥1.
- `CNT_W`, 32: stall counter width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `id_rs_i`  in  5*NUM_RS  ID-stage source registers; port k is at [5k+4:5k].
- `id_rs_vld_i`  in  NUM_RS  port k actually reads its register.
- `id_rd_i`, `id_rd_wr_i`  in  5, 1  ID-stage destination and write enable.
- `id_ex_rs_i`  in  5*NUM_RS  EX-stage source registers.
- `id_ex_mem_rd_i`, `id_ex_reg_rd_i`  in  1, 5  a load is in EX, and its rd.
- `ex_mem_reg_wr_i`, `ex_mem_reg_rd_i`  in  1, 5  EX/MEM writeback info.
- `mem_wb_reg_wr_i`, `mem_wb_reg_rd_i`  in  1, 5  MEM/WB writeback info.
- `lg_issue_i`, `lg_issue_rd_i`  in  1, 5  a long op leaves EX and targets rd.
- `lg_done_i`, `lg_done_rd_i`  in  1, 5  the long op writes the register file this cycle.
- `forward_o`  out  2*NUM_RS  per-port select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 long-unit result.
- `stall_o`  out  1  hold PC/IF-ID and insert a bubble into ID/EX.
- `pend_cnt_o`  out  $clog2(MAX_PEND+1)  number of set busy bits.
- `pend_full_o`  out  1  pend_cnt_o == MAX_PEND.
- `stall_cnt_o`  out  CNT_W  saturating count of stall cycles.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Forwarding, per port k, combinational, priority order:**
  - `ex_mem_reg_wr_i` and rd≠0 and rd==rs_k → 10.
  - Else `mem_wb_reg_wr_i` and rd≠0 and rd==rs_k → 01.
  - Else `lg_wb_vld_q` and `lg_wb_rd_q`==rs_k and rs_k≠0 → 11.
  - Else 00.
- **Long writeback register:** `lg_wb_vld_q`/`lg_wb_rd_q` capture `lg_done_i`/`lg_done_rd_i` every cycle. The datapath holds the long result for exactly one cycle after done.
- **Busy scoreboard:** `busy_q[31:1]`; x0 is never busy.
  - Issue with rd≠0 and not full sets `busy_q[rd]` next cycle.
  - Done clears `busy_q[rd]` next cycle.
  - Issue and done to the same rd in the same cycle: busy stays set (the new issue wins).
- **Effective busy:** `busy_eff = busy_q & ~(lg_done_i ? onehot(lg_done_rd_i) : 0)`. A completing register unmasks the stall in its done cycle; its value then arrives through the 11 path.
- **`stall_o` is the OR of:**
  - Load-use: `id_ex_mem_rd_i` and `id_ex_reg_rd_i`≠0 and it matches any valid `id_rs`.
  - RAW: `busy_eff` set for any valid nonzero `id_rs`.
  - WAW: `id_rd_wr_i` and `busy_eff[id_rd_i]`.
  - `pend_full_o` and `lg_issue_i` is asserted.
- **`pend_cnt_o`** is a registered counter, updated by +1 on accepted issue and −1 on valid done, with net 0 when both occur together.
- **`err_o`** is set, sticky until reset, by any of:
  - Issue while full; the issue is dropped.
  - Done to a register whose `busy_q` bit is clear; no count change.
  - Issue to a register already busy.
- **`stall_cnt_o`** increments on every cycle with `stall_o`=1 and saturates at all-ones.

## Timing
- Reset, asynchronous: `busy_q`=0, `pend_cnt_o`=0, `pend_full_o`=0, `lg_wb_vld_q`=0, `stall_cnt_o`=0, `err_o`=0. As a result `forward_o`=0 and `stall_o`=0 while inputs are idle.
- Reset asserted mid-operation discards all pending entries immediately. The pipeline is flushed by the same reset.
- `forward_o` and `stall_o` are combinational from inputs and registered state, with zero latency.
- Issue in cycle N → busy and stall visible from N+1.
- Done in cycle N → stall released in N. The dependent instruction is in EX in N+1 with select 11.
- A load-use stall lasts exactly one cycle when the producer advances.

## Test plan
- **Forward priority:** EX/MEM wr rd=5, MEM/WB wr rd=5, `id_ex_rs0`=5 → `forward_o[1:0]`=10. With rd=0 on both → 00.
- **Load-use:** load rd=7 in EX, ID reads x7 on port 1 → `stall_o`=1 for one cycle, `stall_cnt_o`=1.
- **Long op:** issue rd=9 at N, ID reads x9 from N+1 → stall N+1..M−1. Done at M → `stall_o`=0 in M, `forward_o`=11 in M+1, `pend_cnt_o` 1→0.
- **Capacity:** with `MAX_PEND`=4, issue rd 1..4 → `pend_full_o`=1. A fifth issue → `stall_o`=1. A forced fifth issue → `err_o`=1 and count stays 4.
- **Simultaneous events:** issue rd=3 while done rd=3 is busy → busy[3] remains set and count is unchanged. WAW with `id_rd_i`=3 → stall.
- **Reset:** with 3 pending and `err_o`=1, pulse `rst_ni` low → all outputs 0 in that same cycle.

Source files
------------

// File: rtl/as_hazard_scoreboard.sv
// as_hazard_scoreboard
// Hazard unit for the 5-stage RV64I pipeline: EX-stage forwarding selects per read port,
// ID stall on load-use / RAW / WAW against in-flight long-latency ops, a per-register busy
// scoreboard for out-of-band completions, and a saturating stall-cycle counter.
//
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   id_rs_i, id_rs_vld_i                   ID source registers and their valid bits
//   id_rd_i, id_rd_wr_i                    ID destination and write enable
//   id_ex_rs_i                             EX-stage source registers (forwarding lookup)
//   id_ex_mem_rd_i, id_ex_reg_rd_i         load in EX and its rd
//   ex_mem_reg_wr_i, ex_mem_reg_rd_i       EX/MEM writeback info
//   mem_wb_reg_wr_i, mem_wb_reg_rd_i       MEM/WB writeback info
//   lg_issue_i, lg_issue_rd_i              long op issued, target rd
//   lg_done_i, lg_done_rd_i                long op writes the regfile this cycle
//   forward_o                              per-port select: 00 rf, 01 MEM/WB, 10 EX/MEM, 11 long
//   stall_o                                hold PC/IF-ID, bubble ID/EX
//   pend_cnt_o, pend_full_o                outstanding long ops and full flag
//   stall_cnt_o                            saturating stall-cycle count
//   err_o                                  sticky protocol error
module as_hazard_scoreboard #(
    parameter int unsigned NUM_RS   = 2,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned PW      = $clog2(MAX_PEND + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5*NUM_RS-1:0]   id_rs_i,
    input  logic [NUM_RS-1:0]     id_rs_vld_i,
    input  logic [4:0]            id_rd_i,
    input  logic                  id_rd_wr_i,
    input  logic [5*NUM_RS-1:0]   id_ex_rs_i,
    input  logic                  id_ex_mem_rd_i,
    input  logic [4:0]            id_ex_reg_rd_i,
    input  logic                  ex_mem_reg_wr_i,
    input  logic [4:0]            ex_mem_reg_rd_i,
    input  logic                  mem_wb_reg_wr_i,
    input  logic [4:0]            mem_wb_reg_rd_i,
    input  logic                  lg_issue_i,
    input  logic [4:0]            lg_issue_rd_i,
    input  logic                  lg_done_i,
    input  logic [4:0]            lg_done_rd_i,
    output logic [2*NUM_RS-1:0]   forward_o,
    output logic                  stall_o,
    output logic [PW-1:0]         pend_cnt_o,
    output logic                  pend_full_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  err_o
);

    logic [31:1]      busy_q, busy_d;
    logic [PW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             lg_wb_vld_q;
    logic [4:0]       lg_wb_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic [31:0] busy_vec, done_mask, busy_eff, busy_nxt;
    logic        pend_full, done_vld, issue_ok, err_evt;

    // Bit 0 is tied low so x0 can be indexed freely and never reads as busy.
    assign busy_vec    = {busy_q, 1'b0};
    assign pend_full   = (pend_cnt_q == PW'(MAX_PEND));

    // A completing register stops stalling in its done cycle; data comes via the 11 path.
    always_comb begin
        done_mask = '0;
        if (lg_done_i) done_mask[lg_done_rd_i] = 1'b1;
    end
    assign busy_eff = busy_vec & ~done_mask;

    assign done_vld = lg_done_i && busy_vec[lg_done_rd_i];
    // Issue to a still-busy register is flagged and dropped so the count tracks busy bits.
    assign issue_ok = lg_issue_i && (lg_issue_rd_i != 5'd0) && !pend_full
                      && !busy_eff[lg_issue_rd_i];
    assign err_evt  = (lg_issue_i && pend_full)
                      || (lg_done_i && !busy_vec[lg_done_rd_i])
                      || (lg_issue_i && busy_eff[lg_issue_rd_i]);

    // Clear before set: same-cycle issue and done to one rd leaves it busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (done_vld) busy_nxt[lg_done_rd_i] = 1'b0;
        if (issue_ok) busy_nxt[lg_issue_rd_i] = 1'b1;
        busy_d     = busy_nxt[31:1];
        pend_cnt_d = pend_cnt_q + PW'(issue_ok) - PW'(done_vld);
        err_d      = err_q | err_evt;
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_comb begin
        forward_o = '0;
        for (int k = 0; k < int'(NUM_RS); k++) begin
            if (ex_mem_reg_wr_i && (ex_mem_reg_rd_i != 5'd0)
                && (ex_mem_reg_rd_i == id_ex_rs_i[5*k +: 5])) begin
                forward_o[2*k +: 2] = 2'b10;
            end else if (mem_wb_reg_wr_i && (mem_wb_reg_rd_i != 5'd0)
                         && (mem_wb_reg_rd_i == id_ex_rs_i[5*k +: 5])) begin
                forward_o[2*k +: 2] = 2'b01;
            end else if (lg_wb_vld_q && (lg_wb_rd_q == id_ex_rs_i[5*k +: 5])
                         && (id_ex_rs_i[5*k +: 5] != 5'd0)) begin
                forward_o[2*k +: 2] = 2'b11;
            end
        end
    end

    always_comb begin
        stall_o = 1'b0;
        for (int k = 0; k < int'(NUM_RS); k++) begin
            if (id_rs_vld_i[k]) begin
                if (id_ex_mem_rd_i && (id_ex_reg_rd_i != 5'd0)
                    && (id_ex_reg_rd_i == id_rs_i[5*k +: 5])) stall_o = 1'b1;
                if (busy_eff[id_rs_i[5*k +: 5]]) stall_o = 1'b1;
            end
        end
        if (id_rd_wr_i && busy_eff[id_rd_i]) stall_o = 1'b1;
        if (pend_full && lg_issue_i) stall_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            pend_cnt_q  <= '0;
            lg_wb_vld_q <= 1'b0;
            lg_wb_rd_q  <= 5'd0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            pend_cnt_q  <= pend_cnt_d;
            lg_wb_vld_q <= lg_done_i;
            lg_wb_rd_q  <= lg_done_rd_i;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pend_cnt_o  = pend_cnt_q;
    assign pend_full_o = pend_full;
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_as_hazard_scoreboard.sv
module tb_as_hazard_scoreboard;

    localparam int NUM_RS   = 2;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = 32;
    localparam int PW       = $clog2(MAX_PEND + 1);

    logic                clk = 1'b0;
    logic                rst_ni;
    logic [5*NUM_RS-1:0] id_rs_i;
    logic [NUM_RS-1:0]   id_rs_vld_i;
    logic [4:0]          id_rd_i;
    logic                id_rd_wr_i;
    logic [5*NUM_RS-1:0] id_ex_rs_i;
    logic                id_ex_mem_rd_i;
    logic [4:0]          id_ex_reg_rd_i;
    logic                ex_mem_reg_wr_i;
    logic [4:0]          ex_mem_reg_rd_i;
    logic                mem_wb_reg_wr_i;
    logic [4:0]          mem_wb_reg_rd_i;
    logic                lg_issue_i;
    logic [4:0]          lg_issue_rd_i;
    logic                lg_done_i;
    logic [4:0]          lg_done_rd_i;
    logic [2*NUM_RS-1:0] forward_o;
    logic                stall_o;
    logic [PW-1:0]       pend_cnt_o;
    logic                pend_full_o;
    logic [CNT_W-1:0]    stall_cnt_o;
    logic                err_o;

    as_hazard_scoreboard #(
        .NUM_RS   (NUM_RS),
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .id_rs_i         (id_rs_i),
        .id_rs_vld_i     (id_rs_vld_i),
        .id_rd_i         (id_rd_i),
        .id_rd_wr_i      (id_rd_wr_i),
        .id_ex_rs_i      (id_ex_rs_i),
        .id_ex_mem_rd_i  (id_ex_mem_rd_i),
        .id_ex_reg_rd_i  (id_ex_reg_rd_i),
        .ex_mem_reg_wr_i (ex_mem_reg_wr_i),
        .ex_mem_reg_rd_i (ex_mem_reg_rd_i),
        .mem_wb_reg_wr_i (mem_wb_reg_wr_i),
        .mem_wb_reg_rd_i (mem_wb_reg_rd_i),
        .lg_issue_i      (lg_issue_i),
        .lg_issue_rd_i   (lg_issue_rd_i),
        .lg_done_i       (lg_done_i),
        .lg_done_rd_i    (lg_done_rd_i),
        .forward_o       (forward_o),
        .stall_o         (stall_o),
        .pend_cnt_o      (pend_cnt_o),
        .pend_full_o     (pend_full_o),
        .stall_cnt_o     (stall_cnt_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: set of busy registers, outstanding count, error flag, stall total.
    bit     mbusy [32];
    int     mcnt;
    bit     merr;
    longint mstall;
    bit     mwb_vld;
    int     mwb_rd;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
        mcnt = 0; merr = 1'b0; mstall = 0; mwb_vld = 1'b0; mwb_rd = 0;
    endtask

    function automatic bit m_busy_now(input int r);
        return (r != 0) && mbusy[r] && !(lg_done_i && int'(lg_done_rd_i) == r);
    endfunction

    function automatic logic [1:0] m_fwd(input int k);
        int rs;
        rs = int'(id_ex_rs_i[5*k +: 5]);
        if (rs == 0) return 2'b00;
        if (ex_mem_reg_wr_i && int'(ex_mem_reg_rd_i) == rs) return 2'b10;
        if (mem_wb_reg_wr_i && int'(mem_wb_reg_rd_i) == rs) return 2'b01;
        if (mwb_vld && mwb_rd == rs) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = 1'b0;
        for (int k = 0; k < NUM_RS; k++) begin
            int rs;
            rs = int'(id_rs_i[5*k +: 5]);
            if (id_rs_vld_i[k] && rs != 0) begin
                if (id_ex_mem_rd_i && int'(id_ex_reg_rd_i) == rs) s = 1'b1;
                if (m_busy_now(rs)) s = 1'b1;
            end
        end
        if (id_rd_wr_i && m_busy_now(int'(id_rd_i))) s = 1'b1;
        if (mcnt == MAX_PEND && lg_issue_i) s = 1'b1;
        return s;
    endfunction

    task automatic model_step();
        int  ir, dr;
        bit  full, dv, acc;
        ir   = int'(lg_issue_rd_i);
        dr   = int'(lg_done_rd_i);
        full = (mcnt == MAX_PEND);
        dv   = lg_done_i && mbusy[dr];
        acc  = lg_issue_i && ir != 0 && !full && !m_busy_now(ir);
        if (lg_issue_i && (full || m_busy_now(ir))) merr = 1'b1;
        if (lg_done_i && !mbusy[dr]) merr = 1'b1;
        if (m_stall() && mstall < 64'h0000_0000_FFFF_FFFF) mstall++;
        if (dv) mbusy[dr] = 1'b0;
        if (acc) mbusy[ir] = 1'b1;
        mcnt = mcnt + int'(acc) - int'(dv);
        mwb_vld = lg_done_i;
        mwb_rd  = dr;
    endtask

    task automatic cmp_all();
        logic [2*NUM_RS-1:0] ef;
        for (int k = 0; k < NUM_RS; k++) ef[2*k +: 2] = m_fwd(k);
        chk("forward", longint'(forward_o), longint'(ef));
        chk("stall", longint'(stall_o), longint'(m_stall()));
        chk("pend_cnt", longint'(pend_cnt_o), longint'(mcnt));
        chk("pend_full", longint'(pend_full_o), longint'(mcnt == MAX_PEND));
        chk("stall_cnt", longint'(stall_cnt_o), mstall);
        chk("err", longint'(err_o), longint'(merr));
    endtask

    // One clock: check mid-cycle, advance the model on the edge the DUT uses.
    task automatic cyc();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        id_rs_i = '0; id_rs_vld_i = '0; id_rd_i = '0; id_rd_wr_i = 1'b0;
        id_ex_rs_i = '0; id_ex_mem_rd_i = 1'b0; id_ex_reg_rd_i = '0;
        ex_mem_reg_wr_i = 1'b0; ex_mem_reg_rd_i = '0;
        mem_wb_reg_wr_i = 1'b0; mem_wb_reg_rd_i = '0;
        lg_issue_i = 1'b0; lg_issue_rd_i = '0; lg_done_i = 1'b0; lg_done_rd_i = '0;
    endtask

    // Asynchronous pulse between edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        idle();
        #1 rst_ni = 1'b0;
        #1;
        chk({tag, "_forward"}, longint'(forward_o), 0);
        chk({tag, "_stall"}, longint'(stall_o), 0);
        chk({tag, "_pend_cnt"}, longint'(pend_cnt_o), 0);
        chk({tag, "_pend_full"}, longint'(pend_full_o), 0);
        chk({tag, "_stall_cnt"}, longint'(stall_cnt_o), 0);
        chk({tag, "_err"}, longint'(err_o), 0);
        model_reset();
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        model_reset();
        #12;
        chk("rst_forward", longint'(forward_o), 0);
        chk("rst_stall", longint'(stall_o), 0);
        chk("rst_err", longint'(err_o), 0);
        rst_ni = 1'b1;
        cyc();

        // Forward priority: EX/MEM beats MEM/WB on both ports.
        ex_mem_reg_wr_i = 1'b1; ex_mem_reg_rd_i = 5'd5;
        mem_wb_reg_wr_i = 1'b1; mem_wb_reg_rd_i = 5'd5;
        id_ex_rs_i = {5'd5, 5'd5};
        #1 chk("fwd_prio_p0", longint'(forward_o[1:0]), 2);
        cyc();
        ex_mem_reg_rd_i = 5'd0; mem_wb_reg_rd_i = 5'd0; id_ex_rs_i = '0;
        #1 chk("fwd_x0", longint'(forward_o), 0);
        cyc();
        mem_wb_reg_rd_i = 5'd6; id_ex_rs_i = {5'd6, 5'd1};
        #1 chk("fwd_memwb_p1", longint'(forward_o), 4'b0100);
        cyc();
        idle();

        // Load-use on port 1, producer then advances into MEM.
        id_ex_mem_rd_i = 1'b1; id_ex_reg_rd_i = 5'd7;
        id_rs_i = {5'd7, 5'd2}; id_rs_vld_i = 2'b10;
        #1 chk("ld_use_stall", longint'(stall_o), 1);
        cyc();
        id_ex_mem_rd_i = 1'b0; id_ex_reg_rd_i = 5'd0; id_rs_vld_i = 2'b00;
        ex_mem_reg_wr_i = 1'b1; ex_mem_reg_rd_i = 5'd7; id_ex_rs_i = {5'd7, 5'd2};
        #1 chk("ld_use_release", longint'(stall_o), 0);
        chk("ld_use_cnt", longint'(stall_cnt_o), 1);
        chk("ld_use_fwd", longint'(forward_o), 4'b1000);
        cyc();
        idle();

        // Long op on x9: three stalled cycles, release on done, 11 select after.
        lg_issue_i = 1'b1; lg_issue_rd_i = 5'd9;
        cyc();
        idle();
        id_rs_i = {5'd0, 5'd9}; id_rs_vld_i = 2'b01;
        #1 chk("long_stall", longint'(stall_o), 1);
        chk("long_pend1", longint'(pend_cnt_o), 1);
        for (int i = 0; i < 3; i++) cyc();
        lg_done_i = 1'b1; lg_done_rd_i = 5'd9;
        #1 chk("long_done_release", longint'(stall_o), 0);
        cyc();
        idle();
        id_ex_rs_i = {5'd0, 5'd9};
        #1 chk("long_fwd11", longint'(forward_o[1:0]), 3);
        chk("long_pend0", longint'(pend_cnt_o), 0);
        chk("long_stall_cnt", longint'(stall_cnt_o), 4);
        chk("long_no_err", longint'(err_o), 0);
        cyc();
        idle();

        // Capacity: fill with x1..x4, then a fifth issue stalls and is dropped.
        for (int r = 1; r <= 4; r++) begin
            lg_issue_i = 1'b1; lg_issue_rd_i = 5'(r);
            cyc();
        end
        idle();
        #1 chk("cap_full", longint'(pend_full_o), 1);
        chk("cap_cnt4", longint'(pend_cnt_o), 4);
        lg_issue_i = 1'b1; lg_issue_rd_i = 5'd5;
        #1 chk("cap_stall", longint'(stall_o), 1);
        cyc();
        idle();
        #1 chk("cap_err", longint'(err_o), 1);
        chk("cap_cnt_hold", longint'(pend_cnt_o), 4);

        // Simultaneous issue/done on x3 keeps it busy; WAW on x3 stalls.
        lg_done_i = 1'b1; lg_done_rd_i = 5'd4;
        cyc();
        lg_done_i = 1'b1; lg_done_rd_i = 5'd3;
        lg_issue_i = 1'b1; lg_issue_rd_i = 5'd3;
        cyc();
        idle();
        #1 chk("sim_cnt3", longint'(pend_cnt_o), 3);
        id_rd_i = 5'd3; id_rd_wr_i = 1'b1;
        #1 chk("waw_stall", longint'(stall_o), 1);
        cyc();
        idle();
        cyc();

        // Reset with 3 pending and err set.
        pulse_reset("mid_rst");
        cyc();

        // Issue to an already-busy register is an error and is not counted.
        lg_issue_i = 1'b1; lg_issue_rd_i = 5'd10;
        cyc();
        cyc();
        idle();
        #1 chk("dup_err", longint'(err_o), 1);
        chk("dup_cnt", longint'(pend_cnt_o), 1);
        cyc();
        pulse_reset("rst2");
        cyc();

        // Issue to x0 is ignored; done to an idle register is an error.
        lg_issue_i = 1'b1; lg_issue_rd_i = 5'd0;
        cyc();
        idle();
        #1 chk("x0_no_err", longint'(err_o), 0);
        chk("x0_cnt", longint'(pend_cnt_o), 0);
        lg_done_i = 1'b1; lg_done_rd_i = 5'd12;
        cyc();
        idle();
        #1 chk("stray_done_err", longint'(err_o), 1);
        chk("stray_done_cnt", longint'(pend_cnt_o), 0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
